// File: rtl/ctrl_pkg.sv
// Shared types and select encodings for the multi-cycle control unit.
// Class decode and per-class datapath selects live here so the top stays a pure sequencer.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CL_NONE   = 4'd0,
    CL_R      = 4'd1,
    CL_I      = 4'd2,
    CL_LOAD   = 4'd3,
    CL_STORE  = 4'd4,
    CL_BRANCH = 4'd5,
    CL_JAL    = 4'd6,
    CL_JALR   = 4'd7,
    CL_AUIPC  = 4'd8,
    CL_LUI    = 4'd9
  } class_e;

  localparam logic [2:0] IMM_R = 3'b000;
  localparam logic [2:0] IMM_I = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_S = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [2:0] IMM_J = 3'b101;

  localparam logic [1:0] RD_ALU = 2'b00;
  localparam logic [1:0] RD_PC4 = 2'b01;
  localparam logic [1:0] RD_IMM = 2'b10;

  localparam logic [1:0] RS1_REG    = 2'b00;
  localparam logic [1:0] RS1_PC     = 2'b01;
  localparam logic [1:0] RS1_PC_JAL = 2'b10;

  typedef struct packed {
    logic [2:0] imme;
    logic [1:0] rd;
    logic [1:0] rs1;
  } sel_t;

  // Flag vector order: {lui, auipc, jalr, jal, load, branch, store, i_type, r_type}.
  // Anything not exactly one-hot maps to CL_NONE.
  function automatic class_e flags_to_class(input logic [8:0] f);
    case (f)
      9'b000000001: return CL_R;
      9'b000000010: return CL_I;
      9'b000000100: return CL_STORE;
      9'b000001000: return CL_BRANCH;
      9'b000010000: return CL_LOAD;
      9'b000100000: return CL_JAL;
      9'b001000000: return CL_JALR;
      9'b010000000: return CL_AUIPC;
      9'b100000000: return CL_LUI;
      default:      return CL_NONE;
    endcase
  endfunction

  function automatic sel_t class_sel(input class_e c);
    case (c)
      CL_I, CL_LOAD: return '{IMM_I, RD_ALU, RS1_REG};
      CL_STORE:      return '{IMM_S, RD_ALU, RS1_REG};
      CL_BRANCH:     return '{IMM_B, RD_ALU, RS1_PC};
      CL_JAL:        return '{IMM_J, RD_PC4, RS1_PC_JAL};
      CL_JALR:       return '{IMM_I, RD_PC4, RS1_REG};
      CL_AUIPC:      return '{IMM_U, RD_ALU, RS1_PC};
      CL_LUI:        return '{IMM_U, RD_IMM, RS1_PC};
      default:       return '{IMM_R, RD_ALU, RS1_REG};
    endcase
  endfunction

endpackage

// File: rtl/req_timer.sv
// Saturating count of consecutive unanswered request cycles.
// expired fires in the LIMIT-th unanswered cycle, so a same-cycle ready always wins.
module req_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (en && cnt != LAST)  cnt <= cnt + W'(1);
  end

  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer over a shared req/ready memory port,
// with request timeout, illegal-class detection and a retired-instruction counter.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r_type,
  input  logic             i_type,
  input  logic             store,
  input  logic             branch,
  input  logic             load,
  input  logic             jal,
  input  logic             jalr,
  input  logic             auipc,
  input  logic             lui,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             we_re,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [2:0]       imme_sel,
  output logic [1:0]       rd_sel,
  output logic [1:0]       rs1_sel,
  output logic             illegal,
  output logic             mem_fault,
  output logic             busy,
  output logic [CNT_W-1:0] instret
);

  localparam logic [2:0] FETCH  = ST_FETCH;
  localparam logic [2:0] DECODE = ST_DECODE;
  localparam logic [2:0] EXEC   = ST_EXEC;
  localparam logic [2:0] MEM    = ST_MEM;
  localparam logic [2:0] WB     = ST_WB;
  localparam logic [2:0] FAULT  = ST_FAULT;

  logic [2:0] state, nxt;
  class_e     cls, dec_cls;
  sel_t       sel;
  logic       tmo, tmr_en, tmr_clr, retire;

  assign dec_cls = flags_to_class({lui, auipc, jalr, jal, load, branch, store, i_type, r_type});

  always_comb begin
    nxt = state;
    case (state)
      FETCH:   if (mem_ready) nxt = DECODE;
               else if (tmo)  nxt = FAULT;
      DECODE:  nxt = (dec_cls != CL_NONE) ? EXEC : FETCH;
      EXEC:    case (cls)
                 CL_LOAD, CL_STORE: nxt = MEM;
                 CL_BRANCH:         nxt = FETCH;
                 default:           nxt = WB;
               endcase
      MEM:     if (mem_ready) nxt = (cls == CL_LOAD) ? WB : FETCH;
               else if (tmo)  nxt = FAULT;
      default: nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      cls   <= CL_NONE;
    end else begin
      state <= nxt;
      if (state == DECODE) cls <= dec_cls;
    end
  end

  // Every state change restarts the window, so FETCH and MEM waits never accumulate.
  assign tmr_en  = mem_req & ~mem_ready;
  assign tmr_clr = mem_ready | (nxt != state);

  generate
    if (MEM_TIMEOUT > 0) begin : g_timer
      req_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmo)
      );
    end else begin : g_no_timer
      assign tmo = 1'b0;
    end
  endgenerate

  assign sel = class_sel(cls);

  always_comb begin
    mem_req   = 1'b0;
    mem_write = 1'b0;
    we_re     = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    illegal   = 1'b0;
    mem_fault = 1'b0;
    imme_sel  = IMM_R;
    rd_sel    = RD_ALU;
    rs1_sel   = RS1_REG;
    retire    = 1'b0;
    case (state)
      FETCH: begin
        // Gated by rst_n so the port is quiet while reset is held.
        mem_req  = rst_n;
        ir_write = rst_n & mem_ready;
      end
      DECODE: begin
        // Flags are only valid in this cycle, so the illegal verdict is taken from them directly.
        illegal  = (dec_cls == CL_NONE);
        pc_write = (dec_cls == CL_NONE);
      end
      EXEC: begin
        {imme_sel, rd_sel, rs1_sel} = sel;
        pc_write = (cls == CL_BRANCH);
        retire   = (cls == CL_BRANCH);
      end
      MEM: begin
        {imme_sel, rd_sel, rs1_sel} = sel;
        mem_req   = 1'b1;
        we_re     = (cls == CL_LOAD);
        mem_write = (cls == CL_STORE);
        // A store finishes here; the PC moves only on the completing cycle.
        pc_write  = (cls == CL_STORE) & mem_ready;
        retire    = (cls == CL_STORE) & mem_ready;
      end
      WB: begin
        {imme_sel, rd_sel, rs1_sel} = sel;
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retire    = 1'b1;
      end
      FAULT: begin
        mem_fault = 1'b1;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state != FETCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret <= '0;
    else if (retire) instret <= instret + CNT_W'(1);
  end

endmodule
